// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory-command path: command word layout,
// opcodes and responder FSM state encodings.
package gpu_mem_pkg;

  localparam int CMD_W = 290;
  localparam int RSP_W = 256;

  // Command word field positions (LSB of each field)
  localparam int OP_LSB   = 288;
  localparam int ADDR_LSB = 264;
  localparam int MASK_LSB = 256;
  localparam int DATA_LSB = 0;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_REQ  = 2'd1;
  localparam logic [1:0] ST_RD_REQ  = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0]   op,
                                                input logic [23:0]  addr,
                                                input logic [7:0]   wmask,
                                                input logic [255:0] wdata);
    return {op, addr, wmask, wdata};
  endfunction

endpackage

// File: rtl/gpu_mem_cmd_responder.sv
// Pops commands from the FWFT command FIFO, runs them one at a time on a
// single-outstanding memory port and pushes read lines to the response FIFO.
module gpu_mem_cmd_responder
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 256,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [CMD_W-1:0]  cmd_q,
  input  logic              cmd_empty,
  output logic              cmd_rdreq,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_wrreq,
  input  logic              rsp_full,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_illegal
);

  logic [1:0]        state;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [MASK_W-1:0] cmd_wmask;
  logic [DATA_W-1:0] cmd_wdata;

  assign cmd_op    = cmd_q[OP_LSB +: 2];
  assign cmd_addr  = cmd_q[ADDR_LSB +: ADDR_W];
  assign cmd_wmask = cmd_q[MASK_LSB +: MASK_W];
  assign cmd_wdata = cmd_q[DATA_LSB +: DATA_W];

  // NOTE: all state and outputs are registers updated with <=, so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state       <= ST_IDLE;
      cmd_rdreq   <= 1'b0;
      rsp_wrreq   <= 1'b0;
      rsp_data    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      // NOTE: pop/push strobes default low each cycle so they are single pulses.
      cmd_rdreq <= 1'b0;
      rsp_wrreq <= 1'b0;

      case (state)
        ST_IDLE: begin
          // While cmd_rdreq is high the FIFO head still shows the command
          // being popped, so it must not be decoded a second time.
          if (!cmd_empty && !cmd_rdreq) begin
            case (cmd_op)
              OP_WRITE: begin
                cmd_rdreq <= 1'b1;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= cmd_addr;
                mem_wmask <= cmd_wmask;
                mem_wdata <= cmd_wdata;
                busy      <= 1'b1;
                state     <= ST_WR_REQ;
              end
              OP_READ: begin
                // Only start a read when its response is guaranteed a slot.
                if (!rsp_full) begin
                  cmd_rdreq <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= cmd_addr;
                  busy      <= 1'b1;
                  state     <= ST_RD_REQ;
                end
              end
              OP_RSVD: begin
                cmd_rdreq   <= 1'b1;
                err_illegal <= 1'b1;
              end
              default: cmd_rdreq <= 1'b1;
            endcase
          end
        end

        ST_WR_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        ST_RD_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              rsp_data  <= mem_rdata;
              rsp_wrreq <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= ST_RD_DATA;
            end
          end
        end

        ST_RD_DATA: begin
          if (mem_rvalid) begin
            rsp_data  <= mem_rdata;
            rsp_wrreq <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
